// File: rtl/mux2_share_arbiter.sv
// mux2_share_arbiter: round-robin owner of one shared 2:1 data lane.
// Break-before-make gap on handover, registered mux output.
module mux2_share_arbiter #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4,
  parameter int GAP      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              done0,
  input  logic              done1,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              sel,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [1:0] GAP_LAST =
    (GAP > 0) ? 2'(GAP - 1) : 2'd0;

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1,
    SWITCH
  } state_t;

  state_t          state_q;
  logic            gnt0_q;
  logic            gnt1_q;
  logic            sel_q;
  logic            last_q;
  logic [HW-1:0]   hold_q;
  logic [HW-1:0]   hold_d;
  logic [1:0]      gap_q;
  logic            mv_q;
  logic [DATA_W-1:0] md_q;

  logic granted;
  logic own_req;
  logic own_done;
  logic oth_req;
  logic at_last;
  logic exit_c;
  logic pick1;

  // Owner-relative view of the inputs and the release decision.
  always_comb begin
    granted  = 1'b0;
    own_req  = 1'b0;
    own_done = 1'b0;
    oth_req  = 1'b0;
    unique case (1'b1)
      state_q == GRANT0: begin
        granted  = 1'b1;
        own_req  = req0;
        own_done = done0;
        oth_req  = req1;
      end
      state_q == GRANT1: begin
        granted  = 1'b1;
        own_req  = req1;
        own_done = done1;
        oth_req  = req0;
      end
      default: begin
        granted  = 1'b0;
      end
    endcase
    at_last = (hold_q == HOLD_LAST);
    exit_c  = granted &
              (own_done | ~own_req | (at_last & oth_req));
    hold_d  = at_last ? '0 : hold_q + 1'b1;
    // Tie goes to whoever did not own the lane last.
    pick1   = req1 & (~req0 | ~last_q);
  end

  // Arbitration FSM with registered grant and select outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      hold_q  <= '0;
      gap_q   <= 2'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            state_q <= pick1 ? GRANT1 : GRANT0;
            gnt0_q  <= ~pick1;
            gnt1_q  <= pick1;
            sel_q   <= pick1;
            hold_q  <= '0;
          end
        end
        GRANT0, GRANT1: begin
          if (exit_c) begin
            state_q <= (GAP > 0) ? SWITCH : IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            last_q  <= (state_q == GRANT1);
            gap_q   <= 2'd0;
          end else begin
            hold_q  <= hold_d;
          end
        end
        SWITCH: begin
          if (gap_q == GAP_LAST) begin
            state_q <= IDLE;
          end else begin
            gap_q   <= gap_q + 2'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Output lane: one-cycle-late copy of the owner's data.
  always_ff @(posedge clk) begin
    if (reset) begin
      mv_q <= 1'b0;
      md_q <= '0;
    end else begin
      mv_q <= granted;
      unique case (1'b1)
        state_q == GRANT0: md_q <= d0;
        state_q == GRANT1: md_q <= d1;
        default:           md_q <= '0;
      endcase
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign sel     = sel_q;
  assign m_valid = mv_q;
  assign m_data  = md_q;

endmodule

// File: tb/tb_mux2_share_arbiter.sv
// tb_mux2_share_arbiter: directed bench for the shared-lane arbiter.
// Two instances (GAP=1 and GAP=0) tracked by an owner/queue-free model.
module tb_mux2_share_arbiter;

  localparam int DW = 1;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0 = 1'b0;
  logic req1 = 1'b0;
  logic done0 = 1'b0;
  logic done1 = 1'b0;
  logic [DW-1:0] d0 = '0;
  logic [DW-1:0] d1 = '0;

  logic a_g0, a_g1, a_sel, a_mv;
  logic [DW-1:0] a_md;
  logic b_g0, b_g1, b_sel, b_mv;
  logic [DW-1:0] b_md;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  mux2_share_arbiter #(
    .DATA_W(DW), .MAX_HOLD(MH), .GAP(1)
  ) u_a (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .done0(done0), .done1(done1),
    .d0(d0), .d1(d1),
    .gnt0(a_g0), .gnt1(a_g1), .sel(a_sel),
    .m_valid(a_mv), .m_data(a_md)
  );

  mux2_share_arbiter #(
    .DATA_W(DW), .MAX_HOLD(MH), .GAP(0)
  ) u_b (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .done0(done0), .done1(done1),
    .d0(d0), .d1(d1),
    .gnt0(b_g0), .gnt1(b_g1), .sel(b_sel),
    .m_valid(b_mv), .m_data(b_md)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Model: owner (-1 none), granted cycles this window,
  // dead cycles still to serve, and the previous owner.
  int m_own[2];
  int m_run[2];
  int m_wait[2];
  int m_last[2];
  logic e_g0[2], e_g1[2], e_sel[2], e_mv[2];
  logic [DW-1:0] e_md[2];

  task automatic mstep(input int k, input int gap);
    logic [1:0] rq;
    logic [1:0] dn;
    int o;
    rq = {req1, req0};
    dn = {done1, done0};
    if (reset) begin
      m_own[k]  = -1;
      m_run[k]  = 0;
      m_wait[k] = 0;
      m_last[k] = 1;
      e_sel[k]  = 1'b0;
      e_mv[k]   = 1'b0;
      e_md[k]   = '0;
    end else begin
      e_mv[k] = (m_own[k] >= 0);
      e_md[k] = (m_own[k] == 1) ? d1 :
                (m_own[k] == 0) ? d0 : '0;
      if (m_own[k] >= 0) begin
        o = m_own[k];
        if (dn[o] || !rq[o] ||
            ((m_run[k] % MH) == MH - 1 && rq[1-o])) begin
          m_last[k] = o;
          m_own[k]  = -1;
          m_wait[k] = gap;
        end else begin
          m_run[k]++;
        end
      end else if (m_wait[k] > 0) begin
        m_wait[k]--;
      end else if (rq != 2'b00) begin
        if (rq == 2'b11) m_own[k] = 1 - m_last[k];
        else m_own[k] = rq[1] ? 1 : 0;
        m_run[k] = 0;
        e_sel[k] = (m_own[k] == 1);
      end
    end
    e_g0[k] = (m_own[k] == 0);
    e_g1[k] = (m_own[k] == 1);
  endtask

  always @(posedge clk) begin
    mstep(0, 1);
    mstep(1, 0);
    if (reset) started <= 1'b1;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("a_gnt0", a_g0, e_g0[0]);
      chk("a_gnt1", a_g1, e_g1[0]);
      chk("a_sel", a_sel, e_sel[0]);
      chk("a_mvalid", a_mv, e_mv[0]);
      chk("a_mdata", a_md, e_md[0]);
      chk("a_excl", a_g0 & a_g1, 0);
      chk("b_gnt0", b_g0, e_g0[1]);
      chk("b_gnt1", b_g1, e_g1[1]);
      chk("b_sel", b_sel, e_sel[1]);
      chk("b_mvalid", b_mv, e_mv[1]);
      chk("b_mdata", b_md, e_md[1]);
      chk("b_excl", b_g0 & b_g1, 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_gnt0", a_g0, 0);
    chk("rst_gnt1", a_g1, 0);
    chk("rst_sel", a_sel, 0);
    chk("rst_mv", a_mv, 0);
    chk("rst_md", a_md, 0);

    // Single requester, done on third granted cycle
    reset = 1'b0;
    req0 = 1'b1;
    d0 = 1'b1;
    d1 = 1'b0;
    step(1);
    chk("t1_gnt_rise", a_g0, 1);
    chk("t1_mv0", a_mv, 0);
    step(1);
    chk("t1_mv1", a_mv, 1);
    chk("t1_md1", a_md, 1);
    step(1);
    chk("t1_mv2", a_mv, 1);
    done0 = 1'b1;
    step(1);
    chk("t1_gnt_fall", a_g0, 0);
    chk("t1_mv3", a_mv, 1);
    done0 = 1'b0;
    req0 = 1'b0;
    step(1);
    chk("t1_mv_end", a_mv, 0);
    chk("t1_gnt_sw", a_g0, 0);
    step(2);

    // Contention with forced rotation, GAP=1
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    step(1);
    chk("t2_g0_first", a_g0, 1);
    chk("t2_sel0", a_sel, 0);
    step(3);
    chk("t2_g0_4th", a_g0, 1);
    step(1);
    chk("t2_sw_g0", a_g0, 0);
    chk("t2_sw_g1", a_g1, 0);
    step(1);
    chk("t2_idle_g1", a_g1, 0);
    step(1);
    chk("t2_g1_first", a_g1, 1);
    chk("t2_sel1", a_sel, 1);
    step(3);
    chk("t2_g1_4th", a_g1, 1);
    step(1);
    chk("t2_g1_off", a_g1, 0);
    chk("t2_sel_hold", a_sel, 1);
    step(2);
    chk("t2_g0_again", a_g0, 1);
    chk("t2_sel_back", a_sel, 0);
    req0 = 1'b0;
    req1 = 1'b0;
    step(3);

    // Uncontended long hold
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    req1 = 1'b1;
    d1 = 1'b1;
    step(1);
    chk("t3_g1", a_g1, 1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t3_hold", a_g1, 1);
    end
    chk("t3_md", a_md, 1);
    req1 = 1'b0;
    d1 = 1'b0;
    step(3);

    // GAP=0 instance, done on each owner's second cycle
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    step(1);
    chk("t4_g0a", b_g0, 1);
    step(1);
    chk("t4_g0b", b_g0, 1);
    done0 = 1'b1;
    step(1);
    done0 = 1'b0;
    chk("t4_idle_g0", b_g0, 0);
    chk("t4_idle_g1", b_g1, 0);
    step(1);
    chk("t4_g1a", b_g1, 1);
    chk("t4_sel1", b_sel, 1);
    step(1);
    chk("t4_g1b", b_g1, 1);
    done1 = 1'b1;
    step(1);
    done1 = 1'b0;
    chk("t4_idle2_g0", b_g0, 0);
    chk("t4_idle2_g1", b_g1, 0);
    step(1);
    chk("t4_g0_again", b_g0, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    step(3);

    // Reset in the middle of a grant
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    req1 = 1'b1;
    d1 = 1'b1;
    step(2);
    chk("t5_g1", a_g1, 1);
    chk("t5_mv", a_mv, 1);
    chk("t5_md", a_md, 1);
    reset = 1'b1;
    req0 = 1'b1;
    step(1);
    chk("t5_rst_g1", a_g1, 0);
    chk("t5_rst_sel", a_sel, 0);
    chk("t5_rst_mv", a_mv, 0);
    chk("t5_rst_md", a_md, 0);
    reset = 1'b0;
    step(1);
    chk("t5_tie_p0", a_g0, 1);

    // Foreign done is ignored
    done1 = 1'b1;
    step(1);
    chk("t6_g0", a_g0, 1);
    done1 = 1'b0;
    step(1);
    chk("t6_g0_still", a_g0, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    step(5);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
